data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_array.sv | 28 ++
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the doubleword data memory responder.
package dmem_pkg;
    localparam int WORD_W          = 64;
    localparam int DEF_DEPTH_WORDS = 32;
    localparam int DEF_LATENCY     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: one synchronous write port, one asynchronous read port,
// whole array cleared synchronously on Reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a fixed wait latency in front
// of a doubleword array; response is held until the initiator takes it.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [63:0] ReqAddress,
    input  logic [63:0] ReqWriteData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] RespReadData,
    output logic        RespError
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [60:0] DEPTH_L = 61'(DEPTH_WORDS);
    localparam logic [2:0]  LAT3    = 3'(LATENCY);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [63:0] r_resp_data;
    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    logic          w_in_idle;
    logic          w_enter_resp;
    logic          w_write;
    logic          w_err;
    logic          w_we;
    logic [63:0]   w_addr;
    logic [63:0]   w_wdata;
    logic [63:0]   w_rdata;
    logic [AW-1:0] w_idx;

    // With zero latency the access happens on the accepting edge, so the live
    // request inputs are used there; otherwise the captured copy is used.
    assign w_in_idle    = (r_state == IDLE);
    assign w_enter_resp = (w_in_idle && ReqValid && (LATENCY == 0)) ||
                          ((r_state == WAIT) && (r_cnt == 3'd1));
    assign w_write      = w_in_idle ? ReqWrite     : r_write;
    assign w_addr       = w_in_idle ? ReqAddress   : r_addr;
    assign w_wdata      = w_in_idle ? ReqWriteData : r_wdata;
    assign w_err        = (w_addr[2:0] != 3'b000) || (w_addr[63:3] >= DEPTH_L);
    assign w_idx        = w_addr[AW+2:3];
    assign w_we         = w_enter_resp && w_write && !w_err;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (w_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            if (w_enter_resp) begin
                r_resp_err  <= w_err;
                r_resp_data <= (w_write || w_err) ? '0 : w_rdata;
            end
            case (r_state)
                IDLE: if (ReqValid) begin
                    r_write     <= ReqWrite;
                    r_addr      <= ReqAddress;
                    r_wdata     <= ReqWriteData;
                    r_req_ready <= 1'b0;
                    if (LATENCY == 0) begin
                        r_state <= RESP;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= LAT3;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) r_state <= RESP;
                end
                // First RESP cycle loads the response; valid rises one edge later.
                RESP: if (!r_resp_valid) begin
                    r_resp_valid <= 1'b1;
                end else if (RespReady) begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ReqReady     = r_req_ready;
    assign RespValid    = r_resp_valid;
    assign RespError    = r_resp_err;
    assign RespReadData = r_resp_data;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: default build (DEPTH 32, LATENCY 2) plus a LATENCY 0 build.
module tb_data_mem_responder;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite, RespValid, RespReady, RespError;
    logic [63:0] ReqAddress, ReqWriteData, RespReadData;
    logic        ReqValid_z, ReqReady_z, ReqWrite_z, RespValid_z, RespReady_z, RespError_z;
    logic [63:0] ReqAddress_z, ReqWriteData_z, RespReadData_z;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_responder u_dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddress(ReqAddress), .ReqWriteData(ReqWriteData),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespReadData(RespReadData), .RespError(RespError)
    );

    data_mem_responder #(.DEPTH_WORDS(32), .LATENCY(0)) u_dut_z (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid_z), .ReqReady(ReqReady_z), .ReqWrite(ReqWrite_z),
        .ReqAddress(ReqAddress_z), .ReqWriteData(ReqWriteData_z),
        .RespValid(RespValid_z), .RespReady(RespReady_z),
        .RespReadData(RespReadData_z), .RespError(RespError_z)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 build; request inputs are scrambled
    // right after acceptance so any late sampling shows up.
    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output logic er, output int lat);
        int g;
        ReqValid = 1'b1; ReqWrite = w; ReqAddress = a; ReqWriteData = d; RespReady = 1'b1;
        g = 0;
        while (!ReqReady && g < 20) begin tick(); g++; end
        chk("ready_before_accept", ReqReady, 1);
        tick();
        ReqValid = 1'b0; ReqWrite = ~w; ReqAddress = ~a; ReqWriteData = ~d;
        lat = 0;
        while (!RespValid && lat < 20) begin tick(); lat++; end
        rd = RespReadData;
        er = RespError;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          g;

        Reset = 1'b1;
        ReqValid = 0; ReqWrite = 0; ReqAddress = 0; ReqWriteData = 0; RespReady = 0;
        ReqValid_z = 0; ReqWrite_z = 0; ReqAddress_z = 0; ReqWriteData_z = 0; RespReady_z = 0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_req_ready", ReqReady, 1);
        chk("rst_resp_valid", RespValid, 0);
        chk("rst_resp_err", RespError, 0);
        chk("rst_resp_data", RespReadData, 0);
        chk("rst_req_ready_l0", ReqReady_z, 1);

        // Store then load back
        txn(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, rd, er, lat);
        chk("st10_lat", lat, 3);
        chk("st10_err", er, 0);
        chk("st10_data", rd, 0);
        chk("st10_valid_drop", RespValid, 0);
        txn(1'b0, 64'h10, 64'h0, rd, er, lat);
        chk("ld10_lat", lat, 3);
        chk("ld10_data", rd, 64'hDEAD_BEEF_0123_4567);
        chk("ld10_err", er, 0);

        // Error cases
        txn(1'b0, 64'h13, 64'h0, rd, er, lat);
        chk("ld13_err", er, 1);
        chk("ld13_data", rd, 0);
        txn(1'b0, 64'h100, 64'h0, rd, er, lat);
        chk("ld100_err", er, 1);
        chk("ld100_data", rd, 0);
        txn(1'b0, 64'h0, 64'h0, rd, er, lat);
        chk("ld0_err", er, 0);
        chk("ld0_data", rd, 0);

        // Back-pressure: response held, second request waits for completion
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddress = 64'h10; RespReady = 1'b0;
        tick();
        ReqWrite = 1'b1; ReqAddress = 64'h18; ReqWriteData = 64'h77;
        g = 0;
        while (!RespValid && g < 20) begin tick(); g++; end
        chk("hold_lat", g, 3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", RespValid, 1);
            chk("hold_data", RespReadData, 64'hDEAD_BEEF_0123_4567);
            chk("hold_ready", ReqReady, 0);
            tick();
        end
        RespReady = 1'b1;
        tick();
        chk("hold_done_valid", RespValid, 0);
        chk("hold_done_ready", ReqReady, 1);
        tick();
        ReqValid = 1'b0;
        chk("second_accepted", ReqReady, 0);
        g = 0;
        while (!RespValid && g < 20) begin tick(); g++; end
        chk("second_err", RespError, 0);
        tick();
        txn(1'b0, 64'h18, 64'h0, rd, er, lat);
        chk("ld18_data", rd, 64'h77);

        // Reset in the second WAIT cycle abandons the store
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddress = 64'h8; ReqWriteData = 64'h55;
        tick();
        ReqValid = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("wrst_req_ready", ReqReady, 1);
        chk("wrst_valid", RespValid, 0);
        chk("wrst_err", RespError, 0);
        chk("wrst_data", RespReadData, 0);
        tick();
        chk("wrst_no_resp", RespValid, 0);
        txn(1'b0, 64'h8, 64'h0, rd, er, lat);
        chk("ld8_after_rst", rd, 0);
        txn(1'b0, 64'h18, 64'h0, rd, er, lat);
        chk("ld18_after_rst", rd, 0);

        // Last word, no aliasing onto word 0
        txn(1'b1, 64'hF8, 64'hA5A5_5A5A_0F0F_F0F0, rd, er, lat);
        chk("stF8_err", er, 0);
        txn(1'b0, 64'hF8, 64'h0, rd, er, lat);
        chk("ldF8_data", rd, 64'hA5A5_5A5A_0F0F_F0F0);
        chk("ldF8_err", er, 0);
        txn(1'b0, 64'h0, 64'h0, rd, er, lat);
        chk("ld0_no_alias", rd, 0);

        // LATENCY=0 build, request held high back to back
        ReqValid_z = 1'b1; ReqWrite_z = 1'b1; ReqAddress_z = 64'h8;
        ReqWriteData_z = 64'h1234; RespReady_z = 1'b1;
        tick();
        chk("l0_valid_k", RespValid_z, 0);
        ReqWrite_z = 1'b0; ReqWriteData_z = 64'h0;
        tick();
        chk("l0_valid_k1", RespValid_z, 1);
        chk("l0_err_k1", RespError_z, 0);
        chk("l0_ready_k1", ReqReady_z, 0);
        tick();
        chk("l0_valid_k2", RespValid_z, 0);
        chk("l0_ready_k2", ReqReady_z, 1);
        tick();
        ReqValid_z = 1'b0;
        chk("l0_ready_k3", ReqReady_z, 0);
        chk("l0_valid_k3", RespValid_z, 0);
        tick();
        chk("l0_valid_k4", RespValid_z, 1);
        chk("l0_data_k4", RespReadData_z, 64'h1234);
        tick();
        chk("l0_valid_k5", RespValid_z, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
